// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner of the system bus with hold-time limit.
// Define ARB_LOCK_EN to add the lock input for LOCK'd back-to-back ownership.
module bus_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
`ifdef ARB_LOCK_EN
  input  logic             lock_i,
`endif
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             timeout_err_o
);
  localparam int HW = $clog2(MAX_HOLD);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e           state_q;
  logic [ID_W-1:0]  ptr_q, id_q, win;
  logic [N_REQ-1:0] grant_q;
  logic [HW-1:0]    hold_q;
  logic             valid_q, err_q, err_d, owner_req, tmo, keep, rel;
  // Scan downward so the nearest set bit after ptr is the last one written.
  always_comb begin
    win = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req_i[(int'(ptr_q) + i) % N_REQ]) win = ID_W'((int'(ptr_q) + i) % N_REQ);
  end
  assign owner_req = req_i[id_q];
  assign tmo       = hold_q == HW'(MAX_HOLD - 1);
`ifdef ARB_LOCK_EN
  assign keep      = done_i && lock_i && owner_req;
`else
  assign keep      = 1'b0;
`endif
  assign rel       = !keep && (done_i || !owner_req || tmo);
  assign err_d     = tmo && !done_i && owner_req;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      err_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|req_i) begin
          state_q <= BUSY;
          grant_q <= N_REQ'(1) << win;
          id_q    <= win;
          valid_q <= 1'b1;
          hold_q  <= '0;
        end
      end else if (keep) begin
        hold_q <= '0;
      end else if (rel) begin
        state_q <= IDLE;
        grant_q <= '0;
        id_q    <= '0;
        valid_q <= 1'b0;
        ptr_q   <= id_q;
        err_q   <= err_d;
      end else begin
        hold_q <= tmo ? hold_q : hold_q + 1'b1;
      end
    end
  end
  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_id_o    = id_q;
  assign timeout_err_o = err_q;
endmodule
